dbus_wb_if: RTL and testbench



---
 rtl/dbus_wb_if_pkg.sv | 20 ++
 rtl/dbus_wb_if_if.sv | 23 ++
 rtl/dbus_wb_if.sv | 148 ++++++++++++++
 tb/tb_dbus_wb_if.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_wb_if_pkg.sv
// Shared constants and types for the MEM-stage to Wishbone data-bus bridge.
package dbus_wb_if_pkg;

  typedef enum logic [1:0] {
    DbusIdle = 2'd0,
    DbusBusy = 2'd1,
    DbusDone = 2'd2
  } dbus_state_e;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic        RstEnable   = 1'b1;

  // Wishbone addresses words; the byte offset travels in the select lanes.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dbus_wb_if_if.sv
// Wishbone classic single-transfer signal bundle between the data-bus bridge and memory.
interface dbus_wb_if_if;

  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/dbus_wb_if.sv
// Converts a MEM-stage memory request into one Wishbone classic cycle, stalling the
// pipeline until ack, with flush abort and an ack timeout that reports a bus error.
module dbus_wb_if
  import dbus_wb_if_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic         cpu_ce_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [3:0]   cpu_sel_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         stallreq_o,
  output logic         bus_err_o,
  dbus_wb_if_if.master wb
);

  localparam int                CNT_W    = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  dbus_state_e      state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      adr_r, dat_r, rd_buf_r;
  logic             we_r, cyc_r, stb_r, bus_err_r;
  logic [3:0]       sel_r;
  logic             start_s, ack_s, abort_s, timeout_s, stallreq_s;

  // Next-state decode; ack has priority over flush, which has priority over timeout.
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    ack_s        = 1'b0;
    abort_s      = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      DbusIdle: begin
        if ((cpu_ce_i == ChipEnable) && !flush_i) begin
          start_s      = 1'b1;
          next_state_s = DbusBusy;
        end else begin
          next_state_s = DbusIdle;
        end
      end
      DbusBusy: begin
        if (wb.wb_ack_i) begin
          ack_s        = 1'b1;
          next_state_s = DbusDone;
        end else if (flush_i) begin
          abort_s      = 1'b1;
          next_state_s = DbusIdle;
        end else if (cnt_r == CNT_LAST) begin
          timeout_s    = 1'b1;
          next_state_s = DbusDone;
        end else begin
          next_state_s = DbusBusy;
        end
      end
      DbusDone: begin
        if (!stall_i || flush_i) begin
          next_state_s = DbusIdle;
        end else begin
          next_state_s = DbusDone;
        end
      end
      default: next_state_s = DbusIdle;
    endcase
  end

  // Stall request: a flushed instruction never holds the pipeline.
  always_comb begin
    stallreq_s = 1'b0;
    if (flush_i) begin
      stallreq_s = 1'b0;
    end else begin
      case (state_r)
        DbusIdle: stallreq_s = cpu_ce_i;
        DbusBusy: stallreq_s = 1'b1;
        DbusDone: stallreq_s = 1'b0;
        default:  stallreq_s = 1'b0;
      endcase
    end
  end

  // State register, bus request registers, timeout counter and load buffer.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_r   <= DbusIdle;
      cnt_r     <= CNT_ZERO;
      adr_r     <= ZeroWord;
      dat_r     <= ZeroWord;
      we_r      <= 1'b0;
      sel_r     <= 4'b0000;
      cyc_r     <= 1'b0;
      stb_r     <= 1'b0;
      rd_buf_r  <= ZeroWord;
      bus_err_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      bus_err_r <= timeout_s;
      if (start_s) begin
        adr_r <= word_align(cpu_addr_i);
        dat_r <= cpu_data_i;
        we_r  <= cpu_we_i;
        sel_r <= cpu_sel_i;
        cyc_r <= 1'b1;
        stb_r <= 1'b1;
        cnt_r <= CNT_ZERO;
      end else if (ack_s || abort_s || timeout_s) begin
        // Bus outputs read as zero whenever no transfer is in flight.
        adr_r <= ZeroWord;
        dat_r <= ZeroWord;
        we_r  <= 1'b0;
        sel_r <= 4'b0000;
        cyc_r <= 1'b0;
        stb_r <= 1'b0;
      end else if ((state_r == DbusBusy) && (cnt_r != CNT_LAST)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      if (ack_s) begin
        rd_buf_r <= (we_r == WriteEnable) ? ZeroWord : wb.wb_dat_i;
      end else if (timeout_s) begin
        rd_buf_r <= ZeroWord;
      end else begin
        rd_buf_r <= rd_buf_r;
      end
    end
  end

  assign wb.wb_adr_o = adr_r;
  assign wb.wb_dat_o = dat_r;
  assign wb.wb_we_o  = we_r;
  assign wb.wb_sel_o = sel_r;
  assign wb.wb_stb_o = stb_r;
  assign wb.wb_cyc_o = cyc_r;
  assign cpu_data_o  = rd_buf_r;
  assign bus_err_o   = bus_err_r;
  assign stallreq_o  = stallreq_s;

endmodule

// File: tb/tb_dbus_wb_if.sv
// Scoreboard bench for dbus_wb_if: directed transfers push expected bus requests and
// results; a monitor checks them whenever a Wishbone cycle starts or ends.
module tb_dbus_wb_if;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } req_t;

  typedef struct {
    int          len;
    logic        err;
    logic [31:0] data;
    logic        done;
  } resp_t;

  logic        clk_s = 1'b0;
  logic        rst_s, stall_s, flush_s, ce_s, we_s;
  logic [31:0] addr_s, wdata_s, cpu_data_s;
  logic [3:0]  sel_s;
  logic        stallreq_s, bus_err_s;

  int          total = 0;
  int          bad = 0;
  int          starts = 0;
  int          err_cnt = 0;
  req_t        req_q[$];
  resp_t       resp_q[$];

  int          slave_waits = 0;
  logic        slave_silent = 1'b0;
  logic [31:0] slave_rdata = 32'h0;
  logic        man_mode = 1'b0;
  logic        man_ack = 1'b0;
  logic [31:0] man_dat = 32'h0;

  dbus_wb_if_if bus ();

  dbus_wb_if #(.ACK_TIMEOUT(4)) dut (
    .clk        (clk_s),
    .rst        (rst_s),
    .stall_i    (stall_s),
    .flush_i    (flush_s),
    .cpu_ce_i   (ce_s),
    .cpu_we_i   (we_s),
    .cpu_addr_i (addr_s),
    .cpu_sel_i  (sel_s),
    .cpu_data_i (wdata_s),
    .cpu_data_o (cpu_data_s),
    .stallreq_o (stallreq_s),
    .bus_err_o  (bus_err_s),
    .wb         (bus.master)
  );

  always #5 clk_s = ~clk_s;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Wishbone slave: acks after slave_waits wait states, or never when silent.
  initial begin
    int bcnt;
    bcnt = 0;
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = 32'h0;
    forever begin
      @(negedge clk_s);
      if (man_mode) begin
        bus.wb_ack_i = man_ack;
        bus.wb_dat_i = man_dat;
        bcnt = 0;
      end else if (bus.wb_cyc_o && bus.wb_stb_o) begin
        if (!slave_silent && bcnt == slave_waits) begin
          bus.wb_ack_i = 1'b1;
          bus.wb_dat_i = slave_rdata;
        end else begin
          bus.wb_ack_i = 1'b0;
          bus.wb_dat_i = 32'h0;
        end
        bcnt++;
      end else begin
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 32'h0;
        bcnt = 0;
      end
    end
  end

  // Monitor: check request fields on cyc rise, result on cyc fall.
  initial begin
    logic  prev_cyc;
    int    len;
    req_t  r;
    resp_t p;
    prev_cyc = 1'b0;
    len = 0;
    forever begin
      @(negedge clk_s);
      err_cnt += int'(bus_err_s);
      if (bus.wb_cyc_o && !prev_cyc) begin
        starts++;
        if (req_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cycle: got start at adr %h want no cycle", bus.wb_adr_o);
        end else begin
          r = req_q.pop_front();
          chk("wb_adr", bus.wb_adr_o, r.adr);
          chk("wb_dat", bus.wb_dat_o, r.dat);
          chk("wb_we", 32'(bus.wb_we_o), 32'(r.we));
          chk("wb_sel", 32'(bus.wb_sel_o), 32'(r.sel));
          chk("wb_stb", 32'(bus.wb_stb_o), 32'd1);
        end
      end
      if (bus.wb_cyc_o) begin
        len++;
      end else if (prev_cyc) begin
        if (resp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_end: got cycle end want none");
        end else begin
          p = resp_q.pop_front();
          chk("cyc_len", 32'(len), 32'(p.len));
          chk("bus_err", 32'(bus_err_s), 32'(p.err));
          chk("cpu_data", cpu_data_s, p.data);
          chk("wb_idle_zero", bus.wb_adr_o | bus.wb_dat_o | 32'(bus.wb_sel_o)
              | 32'(bus.wb_we_o) | 32'(bus.wb_stb_o), 32'd0);
          if (p.done) chk("done_stallreq", 32'(stallreq_s), 32'd0);
        end
        len = 0;
      end
      prev_cyc = bus.wb_cyc_o;
    end
  end

  task automatic run_xfer(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                          input logic [31:0] wdata, input int waits, input logic silent,
                          input logic [31:0] rdata, input int done_cycles,
                          input logic [31:0] exp_adr, input int exp_len,
                          input logic exp_err, input logic [31:0] exp_data);
    int n;
    req_q.push_back('{exp_adr, wdata, we, sel});
    resp_q.push_back('{exp_len, exp_err, exp_data, 1'b1});
    slave_waits = waits;
    slave_silent = silent;
    slave_rdata = rdata;
    @(posedge clk_s); #1;
    ce_s = 1'b1; we_s = we; addr_s = addr; sel_s = sel; wdata_s = wdata;
    stall_s = 1'b1; flush_s = 1'b0;
    @(negedge clk_s);
    chk("stallreq_req", 32'(stallreq_s), 32'd1);
    n = 0;
    while (stallreq_s && n < 20) begin
      @(posedge clk_s); #1;
      @(negedge clk_s);
      n++;
    end
    chk("stall_cycles", 32'(n), 32'(exp_len + 1));
    for (int d = 1; d < done_cycles; d++) begin
      @(posedge clk_s); #1;
      @(negedge clk_s);
      chk("hold_stallreq", 32'(stallreq_s), 32'd0);
      chk("hold_data", cpu_data_s, exp_data);
      chk("hold_cyc", 32'(bus.wb_cyc_o), 32'd0);
    end
    stall_s = 1'b0;
    @(posedge clk_s); #1;
    ce_s = 1'b0; we_s = 1'b0; addr_s = 32'h0; sel_s = 4'b0000; wdata_s = 32'h0;
  endtask

  // Show the bridge is IDLE: a request raises stallreq there but not in DONE.
  task automatic probe_idle(input string name);
    @(posedge clk_s); #1;
    ce_s = 1'b1; stall_s = 1'b1;
    @(negedge clk_s);
    chk(name, 32'(stallreq_s), 32'd1);
    ce_s = 1'b0; stall_s = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_s = 1'b1; stall_s = 1'b0; flush_s = 1'b0; ce_s = 1'b0; we_s = 1'b0;
    addr_s = 32'h0; sel_s = 4'b0000; wdata_s = 32'h0;
    repeat (2) @(posedge clk_s);
    #1 rst_s = 1'b0;
    @(negedge clk_s);
    chk("rst_cyc_stb", 32'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}), 32'd0);
    chk("rst_adr", bus.wb_adr_o, 32'h0);
    chk("rst_dat", bus.wb_dat_o, 32'h0);
    chk("rst_cpu_data", cpu_data_s, 32'h0);
    chk("rst_err_stall", 32'({bus_err_s, stallreq_s}), 32'd0);

    // Zero-wait word load.
    run_xfer(32'h0000_0104, 1'b0, 4'b1111, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1,
             32'h0000_0104, 1, 1'b0, 32'hDEAD_BEEF);
    // Byte store with 3 wait states: store result reads as zero.
    run_xfer(32'h0000_0203, 1'b1, 4'b0001, 32'h5A5A_5A5A, 3, 1'b0, 32'hFFFF_FFFF, 1,
             32'h0000_0200, 4, 1'b0, 32'h0);
    // Silent slave: timeout after exactly 4 BUSY cycles.
    run_xfer(32'h0000_0300, 1'b0, 4'b1111, 32'h0, 0, 1'b1, 32'h0, 1,
             32'h0000_0300, 4, 1'b1, 32'h0);
    // Halfword load with one wait state; lanes pass through, data unshifted.
    run_xfer(32'h0000_0402, 1'b0, 4'b0011, 32'h0, 1, 1'b0, 32'h1111_2222, 1,
             32'h0000_0400, 2, 1'b0, 32'h1111_2222);
    // Ack lands on the last timeout cycle: ack wins, no error.
    run_xfer(32'h0000_0410, 1'b0, 4'b1111, 32'h0, 3, 1'b0, 32'h0BAD_F00D, 1,
             32'h0000_0410, 4, 1'b0, 32'h0BAD_F00D);
    // Stall held after ack with cpu_ce_i still high: DONE lasts 3 cycles.
    run_xfer(32'h0000_0010, 1'b0, 4'b1111, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 3,
             32'h0000_0010, 1, 1'b0, 32'hCAFE_F00D);

    // Flush in the second BUSY cycle: abort, load buffer untouched.
    req_q.push_back('{32'h0000_0500, 32'h0, 1'b0, 4'b1111});
    resp_q.push_back('{2, 1'b0, 32'hCAFE_F00D, 1'b0});
    slave_silent = 1'b1;
    @(posedge clk_s); #1;
    ce_s = 1'b1; we_s = 1'b0; addr_s = 32'h0000_0500; sel_s = 4'b1111; stall_s = 1'b1;
    @(posedge clk_s); #1;
    @(posedge clk_s); #1;
    flush_s = 1'b1;
    @(negedge clk_s);
    chk("flush_stallreq", 32'(stallreq_s), 32'd0);
    @(posedge clk_s); #1;
    flush_s = 1'b0; ce_s = 1'b0; stall_s = 1'b0;
    @(negedge clk_s);
    chk("flush_cyc", 32'({bus.wb_cyc_o, bus.wb_stb_o}), 32'd0);
    probe_idle("flush_idle");

    // Reset during BUSY, then a stray ack while IDLE.
    req_q.push_back('{32'h0000_0604, 32'h1357_9BDF, 1'b1, 4'b1111});
    resp_q.push_back('{2, 1'b0, 32'h0, 1'b0});
    @(posedge clk_s); #1;
    ce_s = 1'b1; we_s = 1'b1; addr_s = 32'h0000_0604; sel_s = 4'b1111;
    wdata_s = 32'h1357_9BDF; stall_s = 1'b1;
    @(posedge clk_s); #1;
    @(posedge clk_s); #1;
    rst_s = 1'b1;
    @(posedge clk_s); #1;
    rst_s = 1'b0; ce_s = 1'b0; we_s = 1'b0; stall_s = 1'b0; wdata_s = 32'h0;
    @(negedge clk_s);
    chk("rst_mid_outputs", 32'({bus.wb_cyc_o, bus.wb_stb_o, bus_err_s, stallreq_s}), 32'd0);
    chk("rst_mid_data", cpu_data_s, 32'h0);
    man_ack = 1'b1; man_dat = 32'hFFFF_FFFF; man_mode = 1'b1;
    repeat (2) @(posedge clk_s);
    @(negedge clk_s);
    chk("late_ack_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("late_ack_data", cpu_data_s, 32'h0);
    man_ack = 1'b0; man_mode = 1'b0;
    probe_idle("rst_idle");

    repeat (3) @(posedge clk_s);
    @(negedge clk_s);
    chk("req_q_left", 32'(req_q.size()), 32'd0);
    chk("resp_q_left", 32'(resp_q.size()), 32'd0);
    chk("wb_cycles", 32'(starts), 32'd8);
    chk("err_pulses", 32'(err_cnt), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
